// File: rtl/ysyx_24110006_ifu_pkg.sv
// Shared types for the instruction fetch unit: FSM state encoding and AXI response codes.
package ysyx_24110006_ifu_pkg;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_ADDR = 2'd1,
        IFU_DATA = 2'd2,
        IFU_HOLD = 2'd3
    } ifu_state_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_24110006_ifu_perf.sv
// IFU performance counters: completed fetches and cycles spent waiting on AR/R.
// Instantiated by the IFU only when IFU_PERF_EN is defined.
module ysyx_24110006_ifu_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_inc,
    input  logic        stall_inc,
    output logic [31:0] o_fetch,
    output logic [31:0] o_stall
);

    logic [31:0] fetch_q, fetch_d;
    logic [31:0] stall_q, stall_d;

    // Both counters wrap naturally modulo 2^32.
    always_comb begin
        fetch_d = fetch_q + {31'd0, fetch_inc};
        stall_d = stall_q + {31'd0, stall_inc};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_q <= '0;
            stall_q <= '0;
        end else begin
            fetch_q <= fetch_d;
            stall_q <= stall_d;
        end
    end

    assign o_fetch = fetch_q;
    assign o_stall = stall_q;

endmodule

// File: rtl/ysyx_24110006_ifu.sv
// Instruction fetch unit: one AXI4-Lite read per PC pulse, result held until decode accepts.
// Optional macro IFU_PERF_EN adds fetch/stall counters; IFU_ASSERT_ON enables the protocol check.
module ysyx_24110006_ifu
    import ysyx_24110006_ifu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_valid,
    output logic [ADDR_W-1:0] o_araddr,
    output logic              o_arvalid,
    input  logic              i_arready,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [1:0]        i_rresp,
    input  logic              i_rvalid,
    output logic              o_rready,
    output logic [DATA_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_fault,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [31:0]       o_perf_fetch,
    output logic [31:0]       o_perf_stall
);

    ifu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fault_q, fault_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        unique case (state_q)
            IFU_IDLE: begin
                if (i_valid) begin
                    addr_d  = i_pc;
                    state_d = IFU_ADDR;
                end
            end
            IFU_ADDR: begin
                if (i_arready) state_d = IFU_DATA;
            end
            IFU_DATA: begin
                if (i_rvalid) begin
                    inst_d  = i_rdata;
                    fault_d = (i_rresp != AXI_RESP_OKAY);
                    pc_d    = addr_q;
                    state_d = IFU_HOLD;
                end
            end
            IFU_HOLD: begin
                if (i_ready) state_d = IFU_IDLE;
            end
            default: state_d = IFU_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= IFU_IDLE;
            addr_q  <= '0;
            inst_q  <= '0;
            pc_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    // Handshake strobes decode directly from the registered state, so they are glitch-free.
    assign o_araddr  = addr_q;
    assign o_arvalid = (state_q == IFU_ADDR);
    assign o_rready  = (state_q == IFU_DATA);
    assign o_valid   = (state_q == IFU_HOLD);
    assign o_inst    = inst_q;
    assign o_pc      = pc_q;
    assign o_fault   = fault_q;

`ifdef IFU_PERF_EN
    ysyx_24110006_ifu_perf u_perf (
        .clk       (i_clock),
        .rst       (i_reset),
        .fetch_inc ((state_q == IFU_DATA) && i_rvalid),
        .stall_inc ((state_q == IFU_ADDR) || (state_q == IFU_DATA)),
        .o_fetch   (o_perf_fetch),
        .o_stall   (o_perf_stall)
    );
`else
    assign o_perf_fetch = 32'h0;
    assign o_perf_stall = 32'h0;
`endif

`ifdef IFU_ASSERT_ON
    always_ff @(posedge i_clock) begin
        if (!i_reset && i_valid)
            assert (state_q == IFU_IDLE) else $error("ifu: i_valid while fetch in flight");
    end
`endif

endmodule

// File: tb/tb_ysyx_24110006_ifu.sv
// Self-checking bench for ysyx_24110006_ifu: transaction-level model plus directed and random stimulus.
module tb_ysyx_24110006_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_pc;
    logic        i_valid;
    logic [31:0] o_araddr;
    logic        o_arvalid;
    logic        i_arready;
    logic [31:0] i_rdata;
    logic [1:0]  i_rresp;
    logic        i_rvalid;
    logic        o_rready;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        o_fault;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_perf_fetch;
    logic [31:0] o_perf_stall;

    always #5 clk = ~clk;

    ysyx_24110006_ifu #(.ADDR_W(32), .DATA_W(32)) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_pc         (i_pc),
        .i_valid      (i_valid),
        .o_araddr     (o_araddr),
        .o_arvalid    (o_arvalid),
        .i_arready    (i_arready),
        .i_rdata      (i_rdata),
        .i_rresp      (i_rresp),
        .i_rvalid     (i_rvalid),
        .o_rready     (o_rready),
        .o_inst       (o_inst),
        .o_pc         (o_pc),
        .o_fault      (o_fault),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_perf_fetch (o_perf_fetch),
        .o_perf_stall (o_perf_stall)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Transaction model: which protocol obligation is currently open, and the last delivered result.
    bit          m_ar_open, m_r_open, m_result_open;
    logic [31:0] m_addr, m_inst, m_pc;
    logic        m_fault;
    int unsigned m_fetch, m_stall;
    int unsigned m_arhs = 0, obs_arhs = 0;

    always @(posedge clk) begin
        if (!rst && o_arvalid && i_arready) obs_arhs++;
        if (rst) begin
            m_ar_open = 0; m_r_open = 0; m_result_open = 0;
            m_inst = 0; m_pc = 0; m_fault = 0; m_fetch = 0; m_stall = 0;
        end else begin
            if (m_ar_open || m_r_open) m_stall++;
            if (m_ar_open && i_arready) m_arhs++;
            if (!(m_ar_open || m_r_open || m_result_open)) begin
                if (i_valid) begin
                    m_ar_open = 1;
                    m_addr = i_pc;
                end
            end else if (m_ar_open) begin
                if (i_arready) begin
                    m_ar_open = 0;
                    m_r_open = 1;
                end
            end else if (m_r_open) begin
                if (i_rvalid) begin
                    m_r_open = 0;
                    m_result_open = 1;
                    m_inst = i_rdata;
                    m_fault = (i_rresp != 2'b00);
                    m_pc = m_addr;
                    m_fetch++;
                end
            end else if (i_ready) begin
                m_result_open = 0;
            end
        end
    end

    bit chk_on = 0;
    always @(negedge clk) begin
        if (chk_on) begin
            chk("arvalid", o_arvalid, m_ar_open);
            if (m_ar_open) chk("araddr", o_araddr, m_addr);
            chk("rready", o_rready, m_r_open);
            chk("valid", o_valid, m_result_open);
            chk("inst", o_inst, m_inst);
            chk("pc", o_pc, m_pc);
            chk("fault", o_fault, m_fault);
            chk("ar_handshakes", obs_arhs, m_arhs);
`ifdef IFU_PERF_EN
            chk("perf_fetch", o_perf_fetch, m_fetch);
            chk("perf_stall", o_perf_stall, m_stall);
`else
            chk("perf_fetch", o_perf_fetch, 0);
            chk("perf_stall", o_perf_stall, 0);
`endif
        end
    end

    int  lat;
    bit  got;
    int unsigned hs0;

    initial begin
        rst = 1; i_pc = 0; i_valid = 0; i_arready = 0; i_rdata = 0;
        i_rresp = 0; i_rvalid = 0; i_ready = 0;
        repeat (2) @(negedge clk);
        chk_on = 1;
        chk("rst_valid", o_valid, 0);
        chk("rst_arvalid", o_arvalid, 0);
        chk("rst_rready", o_rready, 0);
        chk("rst_inst", o_inst, 0);
        chk("rst_perf", {o_perf_fetch, o_perf_stall}, 0);
        rst = 0;

        // Zero-wait fetch: o_valid on the third edge after the i_valid sample.
        i_arready = 1; i_rvalid = 1; i_rdata = 32'h00000413; i_rresp = 2'b00; i_ready = 0;
        i_pc = 32'h20000000; i_valid = 1;
        lat = 0; got = 0;
        for (int n = 1; n <= 8 && !got; n++) begin
            @(negedge clk);
            i_valid = 0;
            if (n == 1) chk("first_araddr", o_araddr, 32'h20000000);
            if (o_valid) begin got = 1; lat = n; end
        end
        chk("latency", lat, 3);
        chk("first_inst", o_inst, 32'h00000413);
        chk("first_pc", o_pc, 32'h20000000);
        chk("first_fault", o_fault, 0);
        i_ready = 1; @(negedge clk); i_ready = 0;

        // AR stalled 5 cycles, then an error response.
        hs0 = obs_arhs;
        i_arready = 0; i_rdata = 32'hdeadbeef; i_rresp = 2'b10;
        i_pc = 32'h20000008; i_valid = 1;
        @(negedge clk); i_valid = 0;
        repeat (5) begin
            chk("stall_arvalid", o_arvalid, 1);
            chk("stall_araddr", o_araddr, 32'h20000008);
            @(negedge clk);
        end
        i_arready = 1;
        repeat (2) @(negedge clk);
        chk("single_ar", obs_arhs - hs0, 1);
        chk("err_valid", o_valid, 1);
        chk("err_fault", o_fault, 1);
        chk("err_inst", o_inst, 32'hdeadbeef);

        // HOLD with decode stalled; a stray i_valid must not start a fetch.
        for (int k = 0; k < 4; k++) begin
            i_valid = (k == 1); i_pc = 32'h30000000;
            @(negedge clk);
            chk("hold_valid", o_valid, 1);
            chk("hold_inst", o_inst, 32'hdeadbeef);
            chk("hold_pc", o_pc, 32'h20000008);
        end
        i_valid = 0;
        chk("hold_no_ar", obs_arhs - hs0, 1);
        i_ready = 1; @(negedge clk); i_ready = 0;
        chk("hold_exit_arvalid", o_arvalid, 0);

        // Reset in DATA abandons the read; the next fetch is clean.
        i_rvalid = 0; i_rresp = 2'b00; i_pc = 32'h20000010; i_valid = 1;
        @(negedge clk); i_valid = 0;
        @(negedge clk);
        chk("data_rready", o_rready, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rstdata_rready", o_rready, 0);
        chk("rstdata_valid", o_valid, 0);
        chk("rstdata_arvalid", o_arvalid, 0);
        i_rvalid = 1; i_rdata = 32'h00100093; i_pc = 32'h20000004; i_valid = 1;
        got = 0;
        for (int n = 1; n <= 8 && !got; n++) begin
            @(negedge clk);
            i_valid = 0;
            if (o_valid) got = 1;
        end
        chk("refetch_got", got, 1);
        chk("refetch_pc", o_pc, 32'h20000004);
        chk("refetch_inst", o_inst, 32'h00100093);
        i_ready = 1; @(negedge clk);

        // Perf: 3 fetches, each with 2 AR stall cycles.
        rst = 1; @(negedge clk); rst = 0;
        for (int f = 0; f < 3; f++) begin
            i_arready = 0; i_pc = 32'h20000100 + f * 4; i_valid = 1;
            @(negedge clk); i_valid = 0;
            repeat (2) @(negedge clk);
            i_arready = 1;
            repeat (3) @(negedge clk);
        end
`ifdef IFU_PERF_EN
        chk("perf3_fetch", o_perf_fetch, 3);
        chk("perf3_stall", o_perf_stall, 12);
`else
        chk("perf3_fetch", o_perf_fetch, 0);
        chk("perf3_stall", o_perf_stall, 0);
`endif

        // Random traffic, including out-of-phase handshakes and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            i_valid   = ($urandom_range(0, 2) == 0);
            i_pc      = $urandom;
            i_arready = $urandom_range(0, 1);
            i_rvalid  = $urandom_range(0, 1);
            i_rdata   = $urandom;
            i_rresp   = 2'($urandom_range(0, 3));
            i_ready   = $urandom_range(0, 1);
            @(negedge clk);
        end
        rst = 0; i_valid = 0; i_arready = 0; i_rvalid = 0; i_ready = 0;
        repeat (2) @(negedge clk);
        chk_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
